mem_access_stage: RTL and testbench

Parametrised memory-access pipeline stage with its M/W pipeline register, placed between the execute stage and the writeback stage. It does the following:
- performs RV32 byte, half and word loads and stores, with sign or zero extension, against an internal byte-lane data memory;
- routes addresses at or above MMIO_BASE to an external request/acknowledge bus, stalling the pipeline until the bus answers or a timeout expires;
- flags misaligned accesses instead of performing them.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// MMIO request/acknowledge bus between the memory-access stage and external devices.
interface mem_access_stage_if;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic        io_ack;
  logic [31:0] io_rdata;

  modport master (
    output io_req, io_we, io_addr, io_wdata, io_be,
    input  io_ack, io_rdata
  );

  modport slave (
    input  io_req, io_we, io_addr, io_wdata, io_be,
    output io_ack, io_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32 memory-access stage with M/W pipeline register: byte-lane data RAM,
// MMIO request/ack bus with timeout, and misalignment detection.
module mem_access_stage #(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        m_ren,
  input  logic        m_wen,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [4:0]  m_rd,
  input  logic        m_regwrite,
  input  logic [2:0]  m_result_src,
  input  logic [31:0] m_pc_plus4,
  input  logic [31:0] m_imm,
  input  logic [31:0] m_pc_offset,
  output logic        stall_o,
  output logic        w_valid,
  output logic        w_regwrite,
  output logic [2:0]  w_result_src,
  output logic [31:0] w_alu_result,
  output logic [31:0] w_read_data,
  output logic [31:0] w_pc_plus4,
  output logic [31:0] w_imm,
  output logic [31:0] w_pc_offset,
  output logic [4:0]  w_rd,
  output logic        w_misalign,
  output logic        w_fault,
  mem_access_stage_if.master io
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE, IO_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_q [DEPTH];

  logic               acc, is_mmio, is_load, is_store;
  logic               is_byte, is_half, is_word, misalign, aligned_mmio;
  logic [1:0]         off;
  logic [IDX_W-1:0]   ram_idx;
  logic [31:0]        ram_rdata;
  logic [31:0]        st_data;
  logic [3:0]         st_be;
  logic               ram_we, in_wait, timeout;
  logic               bubble, io_done, io_to;

  logic               w_valid_d, w_regwrite_d, w_misalign_d, w_fault_d;
  logic [31:0]        w_read_data_d;

  // Byte/halfword extraction at the given offset with sign or zero extension.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  o,
                                          input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{o, 3'b000} +: 8];
    h = word[{o[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  assign acc      = m_valid & (m_ren | m_wen);
  assign is_mmio  = m_addr >= MMIO_BASE;
  assign is_store = acc & m_wen;
  assign is_load  = acc & m_ren & ~m_wen;
  assign off      = m_addr[1:0];
  assign ram_idx  = m_addr[2 +: IDX_W];

  assign is_byte  = (m_funct3 == 3'b000) | (m_funct3 == 3'b100);
  assign is_half  = (m_funct3 == 3'b001) | (m_funct3 == 3'b101);
  assign is_word  = ~is_byte & ~is_half;
  assign misalign = acc & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign aligned_mmio = acc & is_mmio & ~misalign;

  assign in_wait  = (state_q == IO_WAIT);
  assign timeout  = in_wait & (cnt_q == CNT_W'(IO_TIMEOUT));

  // Store data replicated across lanes so the byte enables pick the target lane.
  always_comb begin
    st_data = m_wdata;
    st_be   = 4'hF;
    if (is_byte) begin
      st_data = {4{m_wdata[7:0]}};
      st_be   = 4'b0001 << off;
    end else if (is_half) begin
      st_data = {2{m_wdata[15:0]}};
      st_be   = 4'b0011 << off;
    end
  end

  assign ram_we    = (state_q == IDLE) & is_store & ~is_mmio & ~misalign;
  assign ram_rdata = mem_q[ram_idx];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[ram_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // MMIO sequencing: a request is held for the whole IO_WAIT residency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    bubble  = 1'b0;
    io_done = 1'b0;
    io_to   = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_mmio) begin
          state_d = IO_WAIT;
          cnt_d   = '0;
          stall_o = 1'b1;
          bubble  = 1'b1;
        end
      end
      IO_WAIT: begin
        if (io.io_ack) begin
          io_done = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          io_to   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          bubble  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.io_req   = in_wait;
  assign io.io_we    = in_wait & m_wen;
  assign io.io_addr  = in_wait ? {m_addr[31:2], 2'b00} : 32'h0;
  assign io.io_wdata = in_wait ? st_data : 32'h0;
  assign io.io_be    = in_wait ? st_be : 4'h0;

  // W-stage next values; misaligned and timed-out accesses retire without data.
  always_comb begin
    w_valid_d     = m_valid & ~bubble;
    w_misalign_d  = m_valid & ~bubble & misalign;
    w_fault_d     = io_to;
    w_regwrite_d  = m_valid & ~bubble & m_regwrite & ~misalign & ~io_to;
    w_read_data_d = 32'h0;
    if (is_load & ~misalign & ~io_to) begin
      if (io_done)       w_read_data_d = extract(io.io_rdata, off, m_funct3);
      else if (~is_mmio) w_read_data_d = extract(ram_rdata, off, m_funct3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid      <= 1'b0;
      w_regwrite   <= 1'b0;
      w_result_src <= 3'h0;
      w_alu_result <= 32'h0;
      w_read_data  <= 32'h0;
      w_pc_plus4   <= 32'h0;
      w_imm        <= 32'h0;
      w_pc_offset  <= 32'h0;
      w_rd         <= 5'h0;
      w_misalign   <= 1'b0;
      w_fault      <= 1'b0;
    end else begin
      w_valid      <= w_valid_d;
      w_regwrite   <= w_regwrite_d;
      w_result_src <= m_result_src;
      w_alu_result <= m_addr;
      w_read_data  <= w_read_data_d;
      w_pc_plus4   <= m_pc_plus4;
      w_imm        <= m_imm;
      w_pc_offset  <= m_pc_offset;
      w_rd         <= m_rd;
      w_misalign   <= w_misalign_d;
      w_fault      <= w_fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
  logic        clk, rst;
  logic        m_valid, m_ren, m_wen, m_regwrite;
  logic [2:0]  m_funct3, m_result_src;
  logic [31:0] m_addr, m_wdata, m_pc_plus4, m_imm, m_pc_offset;
  logic [4:0]  m_rd;
  logic        stall_o, w_valid, w_regwrite, w_misalign, w_fault;
  logic [2:0]  w_result_src;
  logic [31:0] w_alu_result, w_read_data, w_pc_plus4, w_imm, w_pc_offset;
  logic [4:0]  w_rd;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage_if bus();

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_ren(m_ren), .m_wen(m_wen), .m_funct3(m_funct3),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_regwrite(m_regwrite),
    .m_result_src(m_result_src), .m_pc_plus4(m_pc_plus4), .m_imm(m_imm),
    .m_pc_offset(m_pc_offset), .stall_o(stall_o),
    .w_valid(w_valid), .w_regwrite(w_regwrite), .w_result_src(w_result_src),
    .w_alu_result(w_alu_result), .w_read_data(w_read_data), .w_pc_plus4(w_pc_plus4),
    .w_imm(w_imm), .w_pc_offset(w_pc_offset), .w_rd(w_rd),
    .w_misalign(w_misalign), .w_fault(w_fault),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic rw);
    m_valid = v; m_ren = r; m_wen = w; m_funct3 = f3; m_addr = a; m_wdata = wd;
    m_rd = rd; m_regwrite = rw; m_result_src = 3'd1;
    m_pc_plus4 = 32'h0000_1004; m_imm = 32'h0000_0010; m_pc_offset = 32'h0000_1010;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.io_ack = 1'b0; bus.io_rdata = 32'h0;
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0);
    #12;
    n_tests++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
    n_tests++; if (w_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_w_read_data: got %h want 0", w_read_data); end
    n_tests++; if (bus.io_req !== 1'b0) begin n_fail++; $display("FAIL reset_io_req: got %b want 0", bus.io_req); end
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_ram_loads();
    drive(1, 0, 1, 3'b010, 32'h10, 32'h1122_3344, 5'd0, 0); step();
    n_tests++; if (w_read_data !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", w_read_data); end
    drive(1, 1, 0, 3'b000, 32'h13, 32'h0, 5'd5, 1); step();
    n_tests++; if (w_read_data !== 32'h0000_0011) begin n_fail++; $display("FAIL lb_13: got %h want 00000011", w_read_data); end
    n_tests++; if (w_rd !== 5'd5 || w_regwrite !== 1'b1 || w_alu_result !== 32'h13) begin n_fail++; $display("FAIL lb_13_fields: got rd=%0d rw=%b alu=%h want 5 1 00000013", w_rd, w_regwrite, w_alu_result); end
    drive(1, 1, 0, 3'b001, 32'h12, 32'h0, 5'd6, 1); step();
    n_tests++; if (w_read_data !== 32'h0000_1122) begin n_fail++; $display("FAIL lh_12: got %h want 00001122", w_read_data); end
    drive(1, 0, 1, 3'b000, 32'h10, 32'h0000_00F0, 5'd0, 0); step();
    drive(1, 1, 0, 3'b100, 32'h10, 32'h0, 5'd7, 1); step();
    n_tests++; if (w_read_data !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu_10: got %h want 000000f0", w_read_data); end
    drive(1, 1, 0, 3'b000, 32'h10, 32'h0, 5'd7, 1); step();
    n_tests++; if (w_read_data !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_10: got %h want fffffff0", w_read_data); end
    drive(1, 1, 0, 3'b010, 32'h1010, 32'h0, 5'd8, 1); step();
    n_tests++; if (w_read_data !== 32'h1122_33F0) begin n_fail++; $display("FAIL lw_wrap: got %h want 112233f0", w_read_data); end
  endtask

  task automatic test_half_store();
    drive(1, 0, 1, 3'b010, 32'h20, 32'h5566_7788, 5'd0, 0); step();
    drive(1, 0, 1, 3'b001, 32'h22, 32'h0000_BEEF, 5'd0, 0); step();
    drive(1, 1, 0, 3'b010, 32'h20, 32'h0, 5'd9, 1); step();
    n_tests++; if (w_read_data !== 32'hBEEF_7788) begin n_fail++; $display("FAIL sh_lw_20: got %h want beef7788", w_read_data); end
    drive(1, 1, 0, 3'b001, 32'h22, 32'h0, 5'd9, 1); step();
    n_tests++; if (w_read_data !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh_22: got %h want ffffbeef", w_read_data); end
    drive(1, 1, 0, 3'b101, 32'h22, 32'h0, 5'd9, 1); step();
    n_tests++; if (w_read_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_22: got %h want 0000beef", w_read_data); end
  endtask

  task automatic test_passthrough();
    drive(1, 0, 0, 3'b000, 32'h0000_0ABC, 32'h0, 5'd12, 1);
    m_result_src = 3'd4; m_pc_plus4 = 32'h0000_2004; m_imm = 32'hFFFF_FFF8; m_pc_offset = 32'h0000_1FF8;
    step();
    n_tests++; if (w_valid !== 1'b1 || w_regwrite !== 1'b1 || w_read_data !== 32'h0 || w_alu_result !== 32'h0ABC) begin n_fail++; $display("FAIL alu_pass: got v=%b rw=%b rd=%h alu=%h want 1 1 0 00000abc", w_valid, w_regwrite, w_read_data, w_alu_result); end
    n_tests++; if (w_result_src !== 3'd4 || w_pc_plus4 !== 32'h2004 || w_imm !== 32'hFFFF_FFF8 || w_pc_offset !== 32'h1FF8) begin n_fail++; $display("FAIL pass_fields: got src=%0d pc4=%h imm=%h off=%h", w_result_src, w_pc_plus4, w_imm, w_pc_offset); end
    drive(0, 1, 0, 3'b010, 32'h10, 32'h0, 5'd3, 1); step();
    n_tests++; if (w_valid !== 1'b0 || w_regwrite !== 1'b0) begin n_fail++; $display("FAIL bubble: got v=%b rw=%b want 0 0", w_valid, w_regwrite); end
  endtask

  task automatic test_mmio_load();
    int stalls = 0;
    bus.io_ack = 1'b0;
    drive(1, 1, 0, 3'b010, 32'h8000_0004, 32'h0, 5'd10, 1); #1;
    if (stall_o) stalls++;
    n_tests++; if (bus.io_req !== 1'b0) begin n_fail++; $display("FAIL mmio_idle_req: got %b want 0", bus.io_req); end
    step();
    if (stall_o) stalls++;
    n_tests++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL mmio_bubble: got %b want 0", w_valid); end
    n_tests++; if (bus.io_req !== 1'b1 || bus.io_we !== 1'b0 || bus.io_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL mmio_req: got req=%b we=%b addr=%h want 1 0 80000004", bus.io_req, bus.io_we, bus.io_addr); end
    step();
    if (stall_o) stalls++;
    bus.io_ack = 1'b1; bus.io_rdata = 32'hCAFE_BABE; #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mmio_ack_stall: got %b want 0", stall_o); end
    n_tests++; if (stalls !== 3) begin n_fail++; $display("FAIL mmio_stall_cycles: got %0d want 3", stalls); end
    step();
    bus.io_ack = 1'b0;
    n_tests++; if (w_valid !== 1'b1 || w_read_data !== 32'hCAFE_BABE || w_regwrite !== 1'b1 || w_fault !== 1'b0) begin n_fail++; $display("FAIL mmio_lw: got v=%b data=%h rw=%b f=%b want 1 cafebabe 1 0", w_valid, w_read_data, w_regwrite, w_fault); end
    drive(1, 1, 0, 3'b100, 32'h8000_0002, 32'h0, 5'd11, 1); step();
    bus.io_ack = 1'b1; bus.io_rdata = 32'h1122_3344; step();
    bus.io_ack = 1'b0;
    n_tests++; if (w_valid !== 1'b1 || w_read_data !== 32'h0000_0022) begin n_fail++; $display("FAIL mmio_lbu: got v=%b data=%h want 1 00000022", w_valid, w_read_data); end
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0); #1;
    n_tests++; if (bus.io_req !== 1'b0) begin n_fail++; $display("FAIL mmio_req_drop: got %b want 0", bus.io_req); end
  endtask

  task automatic test_mmio_store();
    bus.io_ack = 1'b0;
    drive(1, 0, 1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 5'd0, 0); step();
    n_tests++; if (bus.io_be !== 4'b1000 || bus.io_wdata !== 32'hABAB_ABAB || bus.io_we !== 1'b1 || bus.io_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL mmio_sb: got be=%b wd=%h we=%b addr=%h", bus.io_be, bus.io_wdata, bus.io_we, bus.io_addr); end
    step();
    n_tests++; if (bus.io_req !== 1'b1 || bus.io_be !== 4'b1000 || stall_o !== 1'b1) begin n_fail++; $display("FAIL mmio_sb_hold: got req=%b be=%b stall=%b want 1 1000 1", bus.io_req, bus.io_be, stall_o); end
    bus.io_ack = 1'b1; step(); bus.io_ack = 1'b0;
    n_tests++; if (w_valid !== 1'b1 || w_regwrite !== 1'b0 || w_fault !== 1'b0) begin n_fail++; $display("FAIL mmio_sb_retire: got v=%b rw=%b f=%b want 1 0 0", w_valid, w_regwrite, w_fault); end
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_timeout();
    int  req_cnt = 0;
    logic done = 1'b0;
    logic last_stall = 1'b1;
    bus.io_ack = 1'b0;
    drive(1, 1, 0, 3'b010, 32'h8000_0000, 32'h0, 5'd13, 1);
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (w_valid) done = 1'b1;
      else if (bus.io_req) begin req_cnt++; last_stall = stall_o; end
    end
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL timeout_retire: got %b want 1", done); end
    n_tests++; if (req_cnt !== 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 16", req_cnt); end
    n_tests++; if (last_stall !== 1'b0) begin n_fail++; $display("FAIL timeout_stall: got %b want 0", last_stall); end
    n_tests++; if (w_fault !== 1'b1 || w_regwrite !== 1'b0 || w_read_data !== 32'h0) begin n_fail++; $display("FAIL timeout_flags: got f=%b rw=%b data=%h want 1 0 0", w_fault, w_regwrite, w_read_data); end
    // ack on the timeout cycle must complete normally
    drive(1, 1, 0, 3'b010, 32'h8000_0008, 32'h0, 5'd14, 1); step();
    repeat (15) step();
    bus.io_ack = 1'b1; bus.io_rdata = 32'h1234_5678; step(); bus.io_ack = 1'b0;
    n_tests++; if (w_valid !== 1'b1 || w_fault !== 1'b0 || w_read_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ack_at_timeout: got v=%b f=%b data=%h want 1 0 12345678", w_valid, w_fault, w_read_data); end
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_misalign();
    drive(1, 0, 1, 3'b010, 32'h4, 32'hA5A5_A5A5, 5'd0, 0); step();
    drive(1, 1, 0, 3'b010, 32'h6, 32'h0, 5'd15, 1); step();
    n_tests++; if (w_misalign !== 1'b1 || w_regwrite !== 1'b0 || w_read_data !== 32'h0 || w_valid !== 1'b1) begin n_fail++; $display("FAIL lw_misalign: got m=%b rw=%b data=%h v=%b want 1 0 0 1", w_misalign, w_regwrite, w_read_data, w_valid); end
    drive(1, 0, 1, 3'b001, 32'h5, 32'h0000_DEAD, 5'd0, 0); step();
    n_tests++; if (w_misalign !== 1'b1) begin n_fail++; $display("FAIL sh_misalign: got %b want 1", w_misalign); end
    drive(1, 1, 0, 3'b010, 32'h4, 32'h0, 5'd15, 1); step();
    n_tests++; if (w_read_data !== 32'hA5A5_A5A5 || w_misalign !== 1'b0) begin n_fail++; $display("FAIL ram_untouched: got %h m=%b want a5a5a5a5 0", w_read_data, w_misalign); end
    drive(1, 1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd15, 1); #1;
    n_tests++; if (stall_o !== 1'b0 || bus.io_req !== 1'b0) begin n_fail++; $display("FAIL mmio_misalign_nostall: got stall=%b req=%b want 0 0", stall_o, bus.io_req); end
    step();
    n_tests++; if (w_misalign !== 1'b1 || bus.io_req !== 1'b0) begin n_fail++; $display("FAIL mmio_misalign: got m=%b req=%b want 1 0", w_misalign, bus.io_req); end
    drive(0, 0, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic test_reset_mid_io();
    bus.io_ack = 1'b0;
    drive(1, 1, 0, 3'b010, 32'h8000_0000, 32'h0, 5'd16, 1); step(); step();
    n_tests++; if (bus.io_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req: got %b want 1", bus.io_req); end
    #2 rst = 1'b1; #1;
    n_tests++; if (bus.io_req !== 1'b0 || w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got req=%b v=%b want 0 0", bus.io_req, w_valid); end
    m_valid = 1'b0; #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_stall: got %b want 0", stall_o); end
    @(negedge clk); rst = 1'b0;
    step();
    n_tests++; if (bus.io_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_req: got %b want 0", bus.io_req); end
  endtask

  initial begin
    test_reset();
    test_ram_loads();
    test_half_store();
    test_passthrough();
    test_mmio_load();
    test_mmio_store();
    test_timeout();
    test_misalign();
    test_reset_mid_io();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
